interrupt_ack_sequencer: RTL and testbench
==========================================

// Module: interrupt_ack_sequencer
// PURPOSE
//  Acknowledge-side partner of Priority_Resolver in the 8259 PIC. Takes the resolver's
//  one-hot winner, raises INT to the CPU, runs the two-pulse INTA sequence, owns the ISR
//  and priority-rotation state, and handles EOI commands (OCW2).
//  Its isr and priority_rotate outputs feed back into Priority_Resolver.
// PARAMETERS
//  SPURIOUS_LEVEL  3'd7  level reported when the request is gone at the first INTA
//  VEC_W           8     width of the vector byte placed on the data bus
// PORTS
//  clk               in   1  single clock; all state changes on its rising edge
//  reset             in   1  synchronous, active-high
//  interrupt_vector  in   8  one-hot winner from Priority_Resolver; 0 = nothing pending
//  inta_n            in   1  CPU interrupt acknowledge, active low, synchronous to clk
//  vector_base       in   5  ICW2 T7..T3
//  auto_eoi          in   1  ICW4 AEOI mode
//  eoi_valid         in   1  one-cycle OCW2 strobe
//  eoi_r             in   1  OCW2 R bit (rotate)
//  eoi_sl            in   1  OCW2 SL bit (specific)
//  eoi_level         in   3  OCW2 L2..L0
//  int_req           out  1  INT to the CPU
//  isr               out  8  in-service register
//  priority_rotate   out  3  level that currently has highest priority
//  clear_irr         out  8  one-cycle pulse that clears the acknowledged IRR bit
//  data_out          out  8  vector byte
//  data_oe           out  1  data_out valid/drive enable
// BEHAVIOUR
//  Reset: state=IDLE; int_req=0, isr=0, priority_rotate=0, clear_irr=0, data_out=0, data_oe=0.
//    Reset mid-sequence aborts the sequence; any partly served level is dropped.
//  INTA edges come from a registered copy of inta_n: fall = prev&~cur, rise = ~prev&cur.
//  FSM:
//   IDLE: interrupt_vector!=0 -> int_req=1 next cycle; go to REQ.
//   REQ: on INTA fall, latch the level (encode of interrupt_vector).
//    - Vector nonzero: set isr[level], pulse clear_irr[level] for 1 cycle.
//    - Vector zero: level=SPURIOUS_LEVEL, spurious=1, isr and IRR unchanged.
//    - Either case: int_req=0, go to ACK1.
//    - interrupt_vector dropping before the INTA fall keeps int_req high
//      (8259 behaviour: serviced as spurious).
//   ACK1: on the second INTA fall, data_out={vector_base,level} and data_oe=1.
//    data_oe stays 1 while inta_n is low. Go to ACK2.
//   ACK2: on INTA rise, data_oe=0.
//    - auto_eoi && !spurious: clear isr[level].
//    - Go to IDLE. int_req may reassert on the next cycle.
//  EOI (accepted in any state, only on an eoi_valid cycle):
//   sl=0 non-specific: clear the highest-priority set isr bit, searching
//    priority_rotate, +1, ... mod 8. isr==0 -> no-op, no rotation.
//   sl=1 specific: clear isr[eoi_level]. Clearing an already-clear bit is legal.
//   r=1: priority_rotate <= (cleared level + 1) mod 8. Cleared level becomes lowest priority.
//   Level arithmetic is 3-bit and wraps: 7+1 -> 0.
//  Simultaneous ISR set (REQ) and EOI clear on the same bit: the set wins.
//    Clears to other bits still apply.
//  isr/priority_rotate update 1 cycle after the strobe. Data lags the INTA fall by 1 cycle.
// STRUCTURE
//  pic_pkg: state enum {IDLE,REQ,ACK1,ACK2}, SPURIOUS_LEVEL, OCW2 field positions,
//   function onehot_to_level(8)->3.
//  Sub-module isr_priority_finder: combinational.
//   Inputs isr[7:0] and priority_rotate[2:0]; outputs found and level[2:0] for the
//   highest-priority set bit. Used for non-specific EOI.
// TESTING
//  1 interrupt_vector=8'h08, vector_base=5'h11, two INTA pulses -> int_req=1;
//    1st fall: isr=8'h08, clear_irr=8'h08 for 1 cycle; 2nd pulse: data_out=8'h8B, data_oe=1.
//  2 isr=8'h14, rotate=0, non-specific EOI -> isr=8'h10.
//    Repeat with rotate=3 -> isr=8'h04.
//  3 isr=8'h80, eoi_r=1, eoi_sl=0 -> isr=0, priority_rotate=0 (7+1 wrap).
//  4 int_req high, interrupt_vector->0 before 1st INTA -> 2nd pulse data_out={vector_base,3'd7};
//    isr unchanged; no clear_irr pulse.
//  5 auto_eoi=1, IR5 acknowledged -> isr[5]=1 after the 1st fall; isr=0 after the 2nd INTA rise.
//  6 reset asserted in ACK1 -> next cycle all outputs 0, state IDLE, pending request re-raises int_req.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259 acknowledge sequencer: FSM states,
// spurious level, OCW2 bit positions and level/one-hot conversion.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK1 = 2'd2,
        ACK2 = 2'd3
    } pic_state_e;

    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    localparam int OCW2_R_POS   = 7;
    localparam int OCW2_SL_POS  = 6;
    localparam int OCW2_EOI_POS = 5;
    localparam int OCW2_L_MSB   = 2;
    localparam int OCW2_L_LSB   = 0;

    function automatic logic [2:0] onehot_to_level(input logic [7:0] onehot);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                lvl = 3'(i);
            end
        end
        return lvl;
    endfunction

    function automatic logic [7:0] level_to_onehot(input logic [2:0] lvl);
        return 8'd1 << lvl;
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_isr_priority_finder.sv
// Finds the highest-priority set ISR bit, scanning upward from priority_rotate
// with 3-bit wrap; used to pick the level cleared by a non-specific EOI.
module isr_priority_finder (
    input  logic [7:0] isr,
    input  logic [2:0] priority_rotate,
    output logic       found,
    output logic [2:0] level
);

    logic [2:0] idx_s;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        found = |isr;
        level = priority_rotate;
        idx_s = priority_rotate;
        for (int i = 7; i >= 0; i--) begin
            idx_s = priority_rotate + 3'(i);
            if (isr[idx_s]) begin
                level = idx_s;
            end else begin
                level = level;
            end
        end
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259 acknowledge side: raises INT, runs the two-pulse INTA sequence, owns the
// ISR and rotation state and applies OCW2 EOI commands.
module interrupt_ack_sequencer #(
    parameter logic [2:0] SPURIOUS_LEVEL = pic_pkg::SPURIOUS_LEVEL,
    parameter int         VEC_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       interrupt_vector,
    input  logic             inta_n,
    input  logic [4:0]       vector_base,
    input  logic             auto_eoi,
    input  logic             eoi_valid,
    input  logic             eoi_r,
    input  logic             eoi_sl,
    input  logic [2:0]       eoi_level,
    output logic             int_req,
    output logic [7:0]       isr,
    output logic [2:0]       priority_rotate,
    output logic [7:0]       clear_irr,
    output logic [VEC_W-1:0] data_out,
    output logic             data_oe
);
    import pic_pkg::*;

    pic_state_e       state_r, state_nx;
    logic             inta_prev_r;
    logic [2:0]       level_r, level_nx;
    logic             spurious_r, spurious_nx;
    logic             int_req_r, int_req_nx;
    logic [7:0]       isr_r, isr_nx;
    logic [2:0]       rotate_r, rotate_nx;
    logic [7:0]       clear_irr_r, clear_irr_nx;
    logic [VEC_W-1:0] data_out_r, data_out_nx;
    logic             data_oe_r, data_oe_nx;

    logic             inta_fall_s, inta_rise_s;
    logic [7:0]       set_mask_s, aeoi_clr_s, eoi_clr_s;
    logic             found_s;
    logic [2:0]       found_level_s;

    assign inta_fall_s = inta_prev_r & ~inta_n;
    assign inta_rise_s = ~inta_prev_r & inta_n;

    isr_priority_finder u_finder (
        .isr             (isr_r),
        .priority_rotate (rotate_r),
        .found           (found_s),
        .level           (found_level_s)
    );

    // State and every registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            inta_prev_r <= 1'b1;
            level_r     <= 3'd0;
            spurious_r  <= 1'b0;
            int_req_r   <= 1'b0;
            isr_r       <= 8'd0;
            rotate_r    <= 3'd0;
            clear_irr_r <= 8'd0;
            data_out_r  <= '0;
            data_oe_r   <= 1'b0;
        end else begin
            state_r     <= state_nx;
            inta_prev_r <= inta_n;
            level_r     <= level_nx;
            spurious_r  <= spurious_nx;
            int_req_r   <= int_req_nx;
            isr_r       <= isr_nx;
            rotate_r    <= rotate_nx;
            clear_irr_r <= clear_irr_nx;
            data_out_r  <= data_out_nx;
            data_oe_r   <= data_oe_nx;
        end
    end

    // Sequence transitions driven by request and INTA edges.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE:    if (interrupt_vector != 8'd0) state_nx = REQ;  else state_nx = IDLE;
            REQ:     if (inta_fall_s)              state_nx = ACK1; else state_nx = REQ;
            ACK1:    if (inta_fall_s)              state_nx = ACK2; else state_nx = ACK1;
            ACK2:    if (inta_rise_s)              state_nx = IDLE; else state_nx = ACK2;
            default: state_nx = IDLE;
        endcase
    end

    // Per-state output and ISR set/auto-EOI effects.
    always_comb begin
        int_req_nx   = int_req_r;
        level_nx     = level_r;
        spurious_nx  = spurious_r;
        clear_irr_nx = 8'd0;
        data_out_nx  = data_out_r;
        data_oe_nx   = data_oe_r;
        set_mask_s   = 8'd0;
        aeoi_clr_s   = 8'd0;
        case (state_r)
            IDLE: begin
                if (interrupt_vector != 8'd0) int_req_nx = 1'b1;
                else                          int_req_nx = int_req_r;
            end
            REQ: begin
                // A request withdrawn before the first INTA is served as the spurious level.
                if (inta_fall_s) begin
                    int_req_nx = 1'b0;
                    if (interrupt_vector != 8'd0) begin
                        level_nx     = onehot_to_level(interrupt_vector);
                        spurious_nx  = 1'b0;
                        set_mask_s   = level_to_onehot(level_nx);
                        clear_irr_nx = level_to_onehot(level_nx);
                    end else begin
                        level_nx    = SPURIOUS_LEVEL;
                        spurious_nx = 1'b1;
                    end
                end else begin
                    int_req_nx = int_req_r;
                end
            end
            ACK1: begin
                if (inta_fall_s) begin
                    data_out_nx = VEC_W'({vector_base, level_r});
                    data_oe_nx  = 1'b1;
                end else begin
                    data_oe_nx = data_oe_r;
                end
            end
            ACK2: begin
                if (inta_rise_s) begin
                    data_oe_nx = 1'b0;
                    if (auto_eoi && !spurious_r) aeoi_clr_s = level_to_onehot(level_r);
                    else                         aeoi_clr_s = 8'd0;
                end else begin
                    data_oe_nx = data_oe_r;
                end
            end
            default: begin
                int_req_nx = 1'b0;
                data_oe_nx = 1'b0;
            end
        endcase
    end

    // OCW2 EOI decode; a set in the same cycle overrides a clear of that bit.
    always_comb begin
        eoi_clr_s = 8'd0;
        rotate_nx = rotate_r;
        if (eoi_valid) begin
            if (eoi_sl) begin
                eoi_clr_s = level_to_onehot(eoi_level);
                if (eoi_r) rotate_nx = eoi_level + 3'd1;
                else       rotate_nx = rotate_r;
            end else if (found_s) begin
                eoi_clr_s = level_to_onehot(found_level_s);
                if (eoi_r) rotate_nx = found_level_s + 3'd1;
                else       rotate_nx = rotate_r;
            end else begin
                eoi_clr_s = 8'd0;
            end
        end else begin
            eoi_clr_s = 8'd0;
        end
        isr_nx = (isr_r & ~(eoi_clr_s | aeoi_clr_s)) | set_mask_s;
    end

    assign int_req         = int_req_r;
    assign isr             = isr_r;
    assign priority_rotate = rotate_r;
    assign clear_irr       = clear_irr_r;
    assign data_out        = data_out_r;
    assign data_oe         = data_oe_r;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Scoreboard bench: stimulus queues expected vectors, IRR pulses and state
// snapshots; a negedge monitor pops and compares them as the DUT presents them.
module tb_interrupt_ack_sequencer;
    import pic_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] interrupt_vector;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       eoi_valid;
    logic       eoi_r;
    logic       eoi_sl;
    logic [2:0] eoi_level;
    logic       int_req;
    logic [7:0] isr;
    logic [2:0] priority_rotate;
    logic [7:0] clear_irr;
    logic [7:0] data_out;
    logic       data_oe;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       full;
        logic       ir;
        logic [7:0] isr;
        logic [2:0] rot;
    } snap_t;

    logic [7:0] vec_q[$];
    logic [7:0] irr_q[$];
    snap_t      snap_q[$];
    string      name_q[$];
    logic       chk_req = 1'b0;
    logic       end_req = 1'b0;
    logic       doe_prev = 1'b0;

    always #5 clk = ~clk;

    interrupt_ack_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .interrupt_vector (interrupt_vector),
        .inta_n           (inta_n),
        .vector_base      (vector_base),
        .auto_eoi         (auto_eoi),
        .eoi_valid        (eoi_valid),
        .eoi_r            (eoi_r),
        .eoi_sl           (eoi_sl),
        .eoi_level        (eoi_level),
        .int_req          (int_req),
        .isr              (isr),
        .priority_rotate  (priority_rotate),
        .clear_irr        (clear_irr),
        .data_out         (data_out),
        .data_oe          (data_oe)
    );

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        logic [7:0] e8;
        snap_t      s;
        string      nm;
        if (data_oe && !doe_prev) begin
            total++;
            if (vec_q.size() == 0) begin
                bad++;
                $display("FAIL vector: unexpected data_out=%h", data_out);
            end else begin
                e8 = vec_q.pop_front();
                if (data_out !== e8) begin
                    bad++;
                    $display("FAIL vector: got %h expected %h", data_out, e8);
                end
            end
        end
        doe_prev <= data_oe;
        if (clear_irr != 8'd0) begin
            total++;
            if (irr_q.size() == 0) begin
                bad++;
                $display("FAIL clear_irr: unexpected pulse %h", clear_irr);
            end else begin
                e8 = irr_q.pop_front();
                if (clear_irr !== e8) begin
                    bad++;
                    $display("FAIL clear_irr: got %h expected %h", clear_irr, e8);
                end
            end
        end
        if (chk_req && snap_q.size() != 0) begin
            s  = snap_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (int_req !== s.ir || isr !== s.isr || priority_rotate !== s.rot ||
                (s.full && (clear_irr !== 8'd0 || data_out !== 8'd0 || data_oe !== 1'b0))) begin
                bad++;
                $display("FAIL %s: got int_req=%b isr=%h rot=%0d clr=%h dout=%h doe=%b expected int_req=%b isr=%h rot=%0d",
                         nm, int_req, isr, priority_rotate, clear_irr, data_out, data_oe, s.ir, s.isr, s.rot);
            end
        end
        if (end_req) begin
            total += 2;
            if (vec_q.size() != 0) begin
                bad++;
                $display("FAIL vector_left: got %0d pending expected 0", vec_q.size());
            end
            if (irr_q.size() != 0) begin
                bad++;
                $display("FAIL clear_irr_left: got %0d pending expected 0", irr_q.size());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string nm, input logic ir, input logic [7:0] isr_e,
                                input logic [2:0] rot_e, input logic full);
        snap_t s;
        s.full = full; s.ir = ir; s.isr = isr_e; s.rot = rot_e;
        snap_q.push_back(s);
        name_q.push_back(nm);
        chk_req = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic eoi(input logic [7:0] ocw2);
        eoi_r     = ocw2[OCW2_R_POS];
        eoi_sl    = ocw2[OCW2_SL_POS];
        eoi_level = ocw2[OCW2_L_MSB:OCW2_L_LSB];
        eoi_valid = ocw2[OCW2_EOI_POS];
        tick();
        eoi_valid = 1'b0;
    endtask

    task automatic two_pulse_tail();
        tick();
        inta_n = 1'b1; tick(); tick();
        inta_n = 1'b0; tick(); tick();
        inta_n = 1'b1; tick(); tick();
    endtask

    task automatic ack(input logic [2:0] lvl);
        interrupt_vector = 8'd1 << lvl;
        tick();
        irr_q.push_back(8'd1 << lvl);
        vec_q.push_back({vector_base, lvl});
        inta_n = 1'b0;
        tick();
        interrupt_vector = 8'd0;
        two_pulse_tail();
    endtask

    initial begin
        reset = 1'b1; interrupt_vector = 8'd0; inta_n = 1'b1; vector_base = 5'h11;
        auto_eoi = 1'b0; eoi_valid = 1'b0; eoi_r = 1'b0; eoi_sl = 1'b0; eoi_level = 3'd0;
        tick(); tick();
        expect_state("reset", 1'b0, 8'h00, 3'd0, 1'b1);
        reset = 1'b0;

        // 1: IR3 through the full two-pulse sequence
        interrupt_vector = 8'h08;
        tick();
        expect_state("t1_int_req", 1'b1, 8'h00, 3'd0, 1'b0);
        irr_q.push_back(8'h08);
        vec_q.push_back(8'h8B);
        inta_n = 1'b0;
        tick();
        expect_state("t1_first_fall", 1'b0, 8'h08, 3'd0, 1'b0);
        interrupt_vector = 8'h00;
        two_pulse_tail();

        // 2: non-specific EOI with rotate 0 then 3
        eoi(8'h63);
        expect_state("t2_specific_clear", 1'b0, 8'h00, 3'd0, 1'b0);
        ack(3'd2); ack(3'd4);
        expect_state("t2_isr14", 1'b0, 8'h14, 3'd0, 1'b0);
        eoi(8'h20);
        expect_state("t2_ns_rot0", 1'b0, 8'h10, 3'd0, 1'b0);
        ack(3'd2);
        eoi(8'hE2);
        expect_state("t2_spec_rotate", 1'b0, 8'h10, 3'd3, 1'b0);
        ack(3'd2);
        eoi(8'h20);
        expect_state("t2_ns_rot3", 1'b0, 8'h04, 3'd3, 1'b0);

        // 3: empty-ISR EOI is a no-op; rotate from level 7 wraps to 0
        eoi(8'h20);
        expect_state("t3_clear", 1'b0, 8'h00, 3'd3, 1'b0);
        eoi(8'hA0);
        expect_state("t3_empty_noop", 1'b0, 8'h00, 3'd3, 1'b0);
        ack(3'd7);
        expect_state("t3_isr80", 1'b0, 8'h80, 3'd3, 1'b0);
        eoi(8'hA0);
        expect_state("t3_wrap", 1'b0, 8'h00, 3'd0, 1'b0);

        // 4: request withdrawn before the first INTA becomes spurious level 7
        interrupt_vector = 8'h20;
        tick();
        interrupt_vector = 8'h00;
        tick();
        expect_state("t4_int_held", 1'b1, 8'h00, 3'd0, 1'b0);
        vec_q.push_back(8'h8F);
        inta_n = 1'b0;
        two_pulse_tail();
        expect_state("t4_isr_same", 1'b0, 8'h00, 3'd0, 1'b0);

        // 5: auto-EOI clears ISR on the second INTA rise
        vector_base = 5'h0A;
        auto_eoi = 1'b1;
        interrupt_vector = 8'h20;
        tick();
        irr_q.push_back(8'h20);
        vec_q.push_back(8'h55);
        inta_n = 1'b0;
        tick();
        expect_state("t5_isr_set", 1'b0, 8'h20, 3'd0, 1'b0);
        interrupt_vector = 8'h00;
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick(); tick();
        inta_n = 1'b1; tick();
        expect_state("t5_aeoi", 1'b0, 8'h00, 3'd0, 1'b0);
        auto_eoi = 1'b0;
        tick();

        // 7: ISR set and specific EOI of the same bit in one cycle: set wins
        interrupt_vector = 8'h08;
        tick();
        irr_q.push_back(8'h08);
        vec_q.push_back(8'h53);
        inta_n = 1'b0;
        eoi(8'h63);
        expect_state("t7_set_wins", 1'b0, 8'h08, 3'd0, 1'b0);
        interrupt_vector = 8'h00;
        two_pulse_tail();
        eoi(8'h63);
        expect_state("t7_cleared", 1'b0, 8'h00, 3'd0, 1'b0);

        // 6: reset in ACK1 drops everything; pending request re-raises INT
        eoi(8'hE4);
        expect_state("t6_rot5", 1'b0, 8'h00, 3'd5, 1'b0);
        interrupt_vector = 8'h02;
        tick();
        irr_q.push_back(8'h02);
        inta_n = 1'b0;
        tick();
        expect_state("t6_ack1_isr", 1'b0, 8'h02, 3'd5, 1'b0);
        inta_n = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_state("t6_reset", 1'b0, 8'h00, 3'd0, 1'b1);
        tick();
        expect_state("t6_reraise", 1'b1, 8'h00, 3'd0, 1'b0);
        interrupt_vector = 8'h00;
        tick();

        end_req = 1'b1;
        @(negedge clk);
        #1;
        end_req = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
